router_sync_param: RTL and testbench
====================================

# router_sync_param

Parametrised write-side synchroniser for the N-channel router: it latches the destination address on header detection, steers the register block's write enable to one output FIFO, reports that FIFO's full status back to the FSM, and watches every output channel for a stalled reader. It generalises the fixed 1x3 synchroniser with a configurable channel count and timeout, invalid-address detection, and a selectable soft-reset mode. It sits between the router FSM/register block and the NUM_CH output FIFOs.

## Interface
- NUM_CH, 3: number of output channels/FIFOs, 2..8.
- ADDR_W, 2: address width, must satisfy 2**ADDR_W >= NUM_CH.
- TIMEOUT, 30: consecutive stalled cycles before soft reset, >= 2.
- SR_HOLD, 0: 0 = soft_reset is a one-cycle pulse; 1 = soft_reset holds until that channel's vld_out falls.
- CNT_W, derived: $clog2(TIMEOUT+1).

- clock  in  1  single clock, all state on rising edge.
- resetn  in  1  synchronous, active-low reset.
- data_in  in  ADDR_W  header address bits from the input packet.
- detect_add  in  1  FSM header-detect strobe; address is captured when high.
- full  in  NUM_CH  per-FIFO full flags.
- empty  in  NUM_CH  per-FIFO empty flags.
- write_enb_reg  in  1  FSM write request for the current packet byte.
- read_enb  in  NUM_CH  per-channel read enables from the downstream readers.
- write_enb  out  NUM_CH  one-hot FIFO write enable.
- fifo_full  out  1  full flag of the currently addressed FIFO.
- vld_out  out  NUM_CH  per-channel data-valid flag, ~empty.
- soft_reset  out  NUM_CH  per-channel FIFO flush request.
- addr_err  out  1  one-cycle pulse when a captured address is >= NUM_CH.

## Operation
- Address register addr_q (ADDR_W) and addr_vld (1): on a clock edge with detect_add=1, addr_q <= data_in and addr_vld <= (data_in < NUM_CH). When detect_add=0, both hold.
- addr_err: registered; set to 1 on the edge that captures an address >= NUM_CH, and cleared on the next edge unless another invalid capture occurs on that edge.
- write_enb (combinational): one-hot bit addr_q when write_enb_reg=1 and addr_vld=1; otherwise all zero. Writes to an invalid address are dropped silently.
- fifo_full (combinational): full[addr_q] when addr_vld=1, else 0. The FSM therefore does not stall on bad packets.
- vld_out[i] = ~empty[i] (combinational).
- Per-channel timeout counter cnt[i] (CNT_W), where stall[i] = vld_out[i] & ~read_enb[i]:
  - stall[i]=0: cnt[i] <= 0.
  - stall[i]=1 and cnt[i] < TIMEOUT-1: cnt[i] <= cnt[i]+1.
  - stall[i]=1 and cnt[i] == TIMEOUT-1: cnt[i] <= 0 and soft_reset[i] <= 1.
- soft_reset release:
  - SR_HOLD=0: soft_reset[i] returns to 0 on the following edge.
  - SR_HOLD=1: soft_reset[i] stays 1 until an edge samples vld_out[i]=0, then clears on that edge. cnt[i] does not count while soft_reset[i]=1.
- Channels are fully independent; several soft_reset bits may be high at once.

## Timing
- Reset (resetn=0 at an edge): addr_q=0, addr_vld=0, addr_err=0, every cnt=0, every soft_reset=0. write_enb=0 and fifo_full=0 follow immediately through addr_vld. vld_out still tracks empty, including during reset.
- Address latency is 1 cycle: write_enb reflects a new address from the edge after detect_add. If detect_add and write_enb_reg are high in the same cycle, write_enb uses the previously latched address.
- Timeout: with stall continuous from edge 1, soft_reset rises at edge TIMEOUT (30 by default). A single read_enb=1 cycle at any point restarts the count from 0.
- Reset mid-count or mid-hold clears the counter and soft_reset on that edge.
- empty rising mid-count counts as stall=0, so the count clears.

## Test plan
- Reset, then detect_add=1 with data_in=2'b10, then write_enb_reg=1 -> write_enb=3'b100 from the next cycle; full={1,0,0} gives fifo_full=1, and full={0,1,1} gives fifo_full=0.
- data_in=2'b11 captured with NUM_CH=3 -> addr_err high for exactly 1 cycle, write_enb=0 and fifo_full=0 while write_enb_reg=1; a later valid address 2'b01 restores write_enb=3'b010.
- empty=3'b000, read_enb=3'b110, held -> soft_reset[0]=1 at edge 30 for exactly 1 cycle, then reasserts at edge 60; soft_reset[2:1] stay 0 throughout.
- Stall on ch0 for 29 cycles, read_enb[0]=1 for 1 cycle, then stall again -> no soft_reset until 30 further stalled cycles have elapsed.
- SR_HOLD=1, ch1 stalled for 30 cycles -> soft_reset[1] rises and holds; empty[1]=1 asserted 5 cycles later -> soft_reset[1] clears on the next edge.
- resetn=0 at cycle 20 of a ch2 stall, released next cycle with the stall continuing -> soft_reset[2] first rises 30 cycles after reset release; addr_q returns to 0.

Source files
------------

// File: rtl/router_sync_param.sv
// router_sync_param: write-side synchroniser for the N-channel router.
// Latches the packet address, steers FIFO writes, flags stalled readers.
module router_sync_param #(
    parameter int NUM_CH  = 3,
    parameter int ADDR_W  = 2,
    parameter int TIMEOUT = 30,
    parameter int SR_HOLD = 0,
    parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              detect_add,
    input  logic [NUM_CH-1:0] full,
    input  logic [NUM_CH-1:0] empty,
    input  logic              write_enb_reg,
    input  logic [NUM_CH-1:0] read_enb,
    output logic [NUM_CH-1:0] write_enb,
    output logic              fifo_full,
    output logic [NUM_CH-1:0] vld_out,
    output logic [NUM_CH-1:0] soft_reset,
    output logic              addr_err
);

    localparam logic [ADDR_W:0]  NUM_CH_W = (ADDR_W + 1)'(NUM_CH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT - 1);
    localparam bit               HOLD     = (SR_HOLD != 0);

    logic [ADDR_W-1:0] addr_q;
    logic              addr_vld;
    logic [NUM_CH-1:0] addr_sel;
    logic              in_range;

    assign in_range = ({1'b0, data_in} < NUM_CH_W);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            addr_q   <= '0;
            addr_vld <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            addr_err <= detect_add && !in_range;
            if (detect_add) begin
                addr_q   <= data_in;
                addr_vld <= in_range;
            end
        end
    end

    // addr_sel stays all-zero for an out-of-range address, so bad packets
    // neither write nor stall the FSM.
    always_comb begin
        addr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            addr_sel[i] = addr_vld && (addr_q == ADDR_W'(i));
        end
    end

    assign write_enb = write_enb_reg ? addr_sel : '0;
    assign fifo_full = |(full & addr_sel);
    assign vld_out   = ~empty;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic             sr_q;
        logic             stall;

        assign stall         = vld_out[i] & ~read_enb[i];
        assign soft_reset[i] = sr_q;

        always_ff @(posedge clock) begin
            if (!resetn) begin
                cnt  <= '0;
                sr_q <= 1'b0;
            end else if (HOLD && sr_q) begin
                // held flush: counter frozen until the FIFO drains
                cnt <= '0;
                if (!vld_out[i]) begin
                    sr_q <= 1'b0;
                end
            end else begin
                sr_q <= 1'b0;
                if (!stall) begin
                    cnt <= '0;
                end else if (cnt == CNT_MAX) begin
                    cnt  <= '0;
                    sr_q <= 1'b1;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_router_sync_param.sv
// tb_router_sync_param: directed checks of address steering and timeouts.
// Two instances share stimulus: pulse mode (dut) and hold mode (dut_h).
module tb_router_sync_param;

    logic       clock = 1'b0;
    logic       resetn;
    logic [1:0] data_in;
    logic       detect_add;
    logic [2:0] full;
    logic [2:0] empty;
    logic       write_enb_reg;
    logic [2:0] read_enb;

    logic [2:0] write_enb, vld_out, soft_reset;
    logic       fifo_full, addr_err;
    logic [2:0] write_enb_h, vld_out_h, soft_reset_h;
    logic       fifo_full_h, addr_err_h;

    int checks   = 0;
    int failures = 0;
    logic hi_seen;

    always #5 clock = ~clock;

    router_sync_param dut (
        .clock(clock), .resetn(resetn), .data_in(data_in),
        .detect_add(detect_add), .full(full), .empty(empty),
        .write_enb_reg(write_enb_reg), .read_enb(read_enb),
        .write_enb(write_enb), .fifo_full(fifo_full),
        .vld_out(vld_out), .soft_reset(soft_reset),
        .addr_err(addr_err)
    );

    router_sync_param #(.SR_HOLD(1)) dut_h (
        .clock(clock), .resetn(resetn), .data_in(data_in),
        .detect_add(detect_add), .full(full), .empty(empty),
        .write_enb_reg(write_enb_reg), .read_enb(read_enb),
        .write_enb(write_enb_h), .fifo_full(fifo_full_h),
        .vld_out(vld_out_h), .soft_reset(soft_reset_h),
        .addr_err(addr_err_h)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        resetn = 1'b0; data_in = 2'b00; detect_add = 1'b0;
        full = 3'b111; empty = 3'b101; write_enb_reg = 1'b1;
        read_enb = 3'b000;
        tick(); tick();
        chk("rst_we", 32'(write_enb), 32'h0);
        chk("rst_ff", 32'(fifo_full), 32'h0);
        chk("rst_sr", 32'(soft_reset), 32'h0);
        chk("rst_err", 32'(addr_err), 32'h0);
        chk("rst_vld", 32'(vld_out), 32'h2);
        empty = 3'b111; write_enb_reg = 1'b0;
        resetn = 1'b1;
        tick();

        // capture 2 with a concurrent write: old (invalid) address used
        detect_add = 1'b1; data_in = 2'b10; write_enb_reg = 1'b1;
        #1;
        chk("we_same_cyc", 32'(write_enb), 32'h0);
        tick();
        detect_add = 1'b0;
        #1;
        chk("we_addr2", 32'(write_enb), 32'h4);
        full = 3'b100; #1;
        chk("ff_addr2_full", 32'(fifo_full), 32'h1);
        full = 3'b011; #1;
        chk("ff_addr2_free", 32'(fifo_full), 32'h0);
        chk("err_valid", 32'(addr_err), 32'h0);

        // invalid address 3
        detect_add = 1'b1; data_in = 2'b11;
        tick();
        detect_add = 1'b0; full = 3'b111; #1;
        chk("err_pulse", 32'(addr_err), 32'h1);
        chk("we_bad", 32'(write_enb), 32'h0);
        chk("ff_bad", 32'(fifo_full), 32'h0);
        tick();
        chk("err_clear", 32'(addr_err), 32'h0);
        detect_add = 1'b1; data_in = 2'b01;
        tick();
        detect_add = 1'b0; #1;
        chk("we_addr1", 32'(write_enb), 32'h2);
        chk("ff_addr1", 32'(fifo_full), 32'h1);
        write_enb_reg = 1'b0; #1;
        chk("we_idle", 32'(write_enb), 32'h0);

        // continuous stall on ch0, 1-cycle pulse at edges 30 and 60
        empty = 3'b000; read_enb = 3'b110;
        hi_seen = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            tick();
            if (soft_reset[2:1] != 2'b00) hi_seen = 1'b1;
            if (k == 29) chk("to_e29", 32'(soft_reset[0]), 32'h0);
            if (k == 30) chk("to_e30", 32'(soft_reset[0]), 32'h1);
            if (k == 31) chk("to_e31", 32'(soft_reset[0]), 32'h0);
            if (k == 59) chk("to_e59", 32'(soft_reset[0]), 32'h0);
            if (k == 60) chk("to_e60", 32'(soft_reset[0]), 32'h1);
        end
        chk("to_other_ch", 32'(hi_seen), 32'h0);
        read_enb = 3'b111;
        tick();
        chk("to_drop", 32'(soft_reset), 32'h0);

        // read in the middle of a stall restarts the count
        read_enb = 3'b110;
        hi_seen = 1'b0;
        for (int k = 1; k <= 29; k++) begin
            tick();
            if (soft_reset[0]) hi_seen = 1'b1;
        end
        read_enb = 3'b111;
        tick();
        if (soft_reset[0]) hi_seen = 1'b1;
        chk("rd_no_sr", 32'(hi_seen), 32'h0);
        read_enb = 3'b110;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 29) chk("rd_e29", 32'(soft_reset[0]), 32'h0);
            if (k == 30) chk("rd_e30", 32'(soft_reset[0]), 32'h1);
        end

        // hold mode on ch1
        resetn = 1'b0; empty = 3'b111; read_enb = 3'b000;
        tick();
        chk("h_rst", 32'(soft_reset_h), 32'h0);
        resetn = 1'b1; empty = 3'b101;
        for (int k = 1; k <= 35; k++) begin
            tick();
            if (k == 29) chk("h_e29", 32'(soft_reset_h[1]), 32'h0);
            if (k == 30) chk("h_e30", 32'(soft_reset_h[1]), 32'h1);
            if (k == 31) chk("h_e31", 32'(soft_reset_h[1]), 32'h1);
            if (k == 31) chk("p_e31", 32'(soft_reset[1]), 32'h0);
            if (k == 35) chk("h_e35", 32'(soft_reset_h), 32'h2);
        end
        empty = 3'b111; #1;
        chk("h_pre_clr", 32'(soft_reset_h[1]), 32'h1);
        tick();
        chk("h_clr", 32'(soft_reset_h), 32'h0);

        // reset in the middle of a ch2 stall
        detect_add = 1'b1; data_in = 2'b01;
        tick();
        detect_add = 1'b0; write_enb_reg = 1'b1;
        empty = 3'b011; read_enb = 3'b000;
        for (int k = 1; k <= 19; k++) tick();
        chk("mr_pre_we", 32'(write_enb), 32'h2);
        resetn = 1'b0;
        tick();
        chk("mr_sr", 32'(soft_reset), 32'h0);
        chk("mr_we", 32'(write_enb), 32'h0);
        chk("mr_addr", 32'(dut.addr_q), 32'h0);
        resetn = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
            if (k == 29) chk("mr_e29", 32'(soft_reset), 32'h0);
            if (k == 30) chk("mr_e30", 32'(soft_reset), 32'h4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
